// File: rtl/spi_cfg_master_if.sv
// Request/response bus between a configuration client and spi_cfg_master.
interface spi_cfg_master_if #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 16
);
   logic              req_valid;
   logic              req_ready;
   logic              req_rd;
   logic [ADDR_W-1:0] req_addr;
   logic [WIDTH-1:0]  req_wdata;
   logic              rsp_valid;
   logic [WIDTH-1:0]  rsp_rdata;
   logic              rsp_err;

   // The client issues requests; the SPI master accepts them and answers.
   modport master (output req_valid, req_rd, req_addr, req_wdata,
                   input  req_ready, rsp_valid, rsp_rdata, rsp_err);
   modport slave  (input  req_valid, req_rd, req_addr, req_wdata,
                   output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

// File: rtl/spi_cfg_master.sv
// SPI mode-0 master that serialises one configuration request per cs_n frame.
// Define SPI_CFG_MASTER_READ_EN for read frames; otherwise reads are rejected with rsp_err.
module spi_cfg_master #(
   parameter int WIDTH   = 16,
   parameter int ADDR_W  = 16,
   parameter int CLK_DIV = 2
) (
   input  logic            clk,
   input  logic            rst,
   spi_cfg_master_if.slave bus,
   output logic            sclk,
   output logic            cs_n,
   output logic            mosi,
   input  logic            miso
);
   localparam int FRAME  = 8 + ADDR_W + WIDTH;
   localparam int BCNT_W = $clog2(FRAME + 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SETUP = 3'd1;
   localparam logic [2:0] S_SHIFT = 3'd2;
   localparam logic [2:0] S_HOLD  = 3'd3;
   localparam logic [2:0] S_GAP   = 3'd4;

   localparam logic [7:0]        DIV_LOAD  = 8'(CLK_DIV);
   localparam logic [BCNT_W-1:0] BCNT_LOAD = BCNT_W'(FRAME);
   localparam logic [7:0]        CMD_WR    = 8'h01;
   localparam logic [7:0]        CMD_RD    = 8'h02;

   logic [2:0]        state_q, state_d;
   logic [7:0]        div_q, div_d;
   logic [BCNT_W-1:0] bcnt_q, bcnt_d;
   logic [FRAME-1:0]  tx_q, tx_d;
   logic              sclk_q, sclk_d;
   logic              cs_n_q, cs_n_d;
   logic              mosi_q, mosi_d;
   logic              ready_q, ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_err_q, rsp_err_d;
   logic [WIDTH-1:0]  rdata_q, rdata_d;
`ifdef SPI_CFG_MASTER_READ_EN
   logic              rd_q, rd_d;
   logic [WIDTH-1:0]  rx_q, rx_d;
`endif

   logic [FRAME-1:0]  frame_s;
   logic              accept_s;
   logic              reject_s;
   logic              expire_s;

   assign frame_s  = {(bus.req_rd ? CMD_RD : CMD_WR), bus.req_addr,
                      (bus.req_rd ? {WIDTH{1'b0}} : bus.req_wdata)};
   assign accept_s = (state_q == S_IDLE) && bus.req_valid && ready_q;
   assign expire_s = (div_q == 8'd1);
`ifdef SPI_CFG_MASTER_READ_EN
   assign reject_s = 1'b0;
`else
   assign reject_s = bus.req_rd;
`endif

   // Next-state logic: frame sequencing, SCLK divider and shift registers.
   always_comb begin
      state_d     = state_q;
      div_d       = div_q;
      bcnt_d      = bcnt_q;
      tx_d        = tx_q;
      sclk_d      = sclk_q;
      cs_n_d      = cs_n_q;
      mosi_d      = mosi_q;
      ready_d     = ready_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = rsp_err_q;
      rdata_d     = rdata_q;
`ifdef SPI_CFG_MASTER_READ_EN
      rd_d        = rd_q;
      rx_d        = rx_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (accept_s && reject_s) begin
               // Rejected read: answer next cycle, reuse GAP as a one-cycle wait.
               ready_d     = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rdata_d     = {WIDTH{1'b0}};
               div_d       = 8'd1;
               state_d     = S_GAP;
            end else if (accept_s) begin
               ready_d = 1'b0;
               tx_d    = frame_s;
               mosi_d  = frame_s[FRAME-1];
               cs_n_d  = 1'b0;
               sclk_d  = 1'b0;
               div_d   = DIV_LOAD;
               bcnt_d  = BCNT_LOAD;
               state_d = S_SETUP;
`ifdef SPI_CFG_MASTER_READ_EN
               rd_d    = bus.req_rd;
`endif
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SETUP: begin
            if (expire_s) begin
               div_d   = DIV_LOAD;
               sclk_d  = 1'b1;
               state_d = S_SHIFT;
            end else begin
               div_d = div_q - 8'd1;
            end
         end
         S_SHIFT: begin
            if (expire_s) begin
               div_d  = DIV_LOAD;
               sclk_d = ~sclk_q;
               if (sclk_q) begin
                  // End of high phase: sample miso, then present the next bit.
                  tx_d   = {tx_q[FRAME-2:0], 1'b0};
                  mosi_d = tx_q[FRAME-2];
                  bcnt_d = bcnt_q - {{(BCNT_W-1){1'b0}}, 1'b1};
`ifdef SPI_CFG_MASTER_READ_EN
                  rx_d   = {rx_q[WIDTH-2:0], miso};
`endif
                  if (bcnt_q == {{(BCNT_W-1){1'b0}}, 1'b1}) begin
                     state_d = S_HOLD;
                  end else begin
                     state_d = S_SHIFT;
                  end
               end else begin
                  bcnt_d = bcnt_q;
               end
            end else begin
               div_d = div_q - 8'd1;
            end
         end
         S_HOLD: begin
            if (expire_s) begin
               div_d       = DIV_LOAD;
               cs_n_d      = 1'b1;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
`ifdef SPI_CFG_MASTER_READ_EN
               rdata_d     = rd_q ? rx_q : {WIDTH{1'b0}};
`else
               rdata_d     = {WIDTH{1'b0}};
`endif
               state_d     = S_GAP;
            end else begin
               div_d = div_q - 8'd1;
            end
         end
         S_GAP: begin
            if (expire_s) begin
               div_d   = DIV_LOAD;
               ready_d = 1'b1;
               state_d = S_IDLE;
            end else begin
               div_d = div_q - 8'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            ready_d = 1'b1;
            cs_n_d  = 1'b1;
            sclk_d  = 1'b0;
            mosi_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; async reset abandons any frame in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         div_q       <= DIV_LOAD;
         bcnt_q      <= {BCNT_W{1'b0}};
         tx_q        <= {FRAME{1'b0}};
         sclk_q      <= 1'b0;
         cs_n_q      <= 1'b1;
         mosi_q      <= 1'b0;
         ready_q     <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rdata_q     <= {WIDTH{1'b0}};
`ifdef SPI_CFG_MASTER_READ_EN
         rd_q        <= 1'b0;
         rx_q        <= {WIDTH{1'b0}};
`endif
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         bcnt_q      <= bcnt_d;
         tx_q        <= tx_d;
         sclk_q      <= sclk_d;
         cs_n_q      <= cs_n_d;
         mosi_q      <= mosi_d;
         ready_q     <= ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rdata_q     <= rdata_d;
`ifdef SPI_CFG_MASTER_READ_EN
         rd_q        <= rd_d;
         rx_q        <= rx_d;
`endif
      end
   end

   assign sclk          = sclk_q;
   assign cs_n          = cs_n_q;
   assign mosi          = mosi_q;
   assign bus.req_ready = ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_rdata = rdata_q;
endmodule

// File: tb/tb_spi_cfg_master.sv
// Scoreboard bench for spi_cfg_master: stimulus pushes expected responses, a monitor pops and compares.
module tb_spi_cfg_master;
   localparam int WIDTH   = 16;
   localparam int ADDR_W  = 16;
   localparam int CLK_DIV = 2;
   localparam int FRAME   = 40;
   // Spec offsets "T0+n" are seen at the falling edge after rising edge T0+n-1.
   localparam int RSP_OFS = 1 + (2 * FRAME + 1) * CLK_DIV;
   localparam int REJ_OFS = 1;

   typedef struct {
      logic [15:0] rdata;
      logic        err;
      int          cyc;
      int          falls;
      logic        has_frame;
      logic [39:0] frame;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        sclk;
   logic        cs_n;
   logic        mosi;
   logic        miso;
   logic [39:0] sl_word;
   logic [39:0] cap;
   int          ncap;
   int          cyc;
   int          ncomp;
   int          nfail;
   int          exp_frames;
   int          cs_falls;
   int          last_rise;
   int          last_gap;
   exp_t        exp_q[$];

   spi_cfg_master_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

   spi_cfg_master #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .CLK_DIV(CLK_DIV)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .sclk (sclk),
      .cs_n (cs_n),
      .mosi (mosi),
      .miso (miso)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Slave model: capture mosi on sclk rise, present sl_word bit for the current high phase.
   always @(posedge sclk or negedge cs_n) begin
      if (sclk) begin
         cap  <= {cap[38:0], mosi};
         ncap <= ncap + 1;
      end else begin
         cap  <= 40'h0;
         ncap <= 0;
      end
   end
   assign miso = (ncap >= 1 && ncap <= 40) ? sl_word[40 - ncap] : 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      ncomp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send(input logic rd, input logic [15:0] addr, input logic [15:0] wdata,
                       input logic hold, input logic [15:0] exp_rdata, input logic exp_err,
                       input logic [39:0] exp_frame, output int t0);
      exp_t e;
      int   n;
      bus.req_valid = 1'b1;
      bus.req_rd    = rd;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      n = 0;
      while (!bus.req_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("accept", {63'h0, bus.req_ready}, 64'h1);
      t0          = cyc + 1;
      e.rdata     = exp_rdata;
      e.err       = exp_err;
      e.has_frame = !exp_err;
      e.frame     = exp_frame;
      if (exp_err) begin
         e.cyc   = t0 + REJ_OFS - 1;
         e.falls = exp_frames;
      end else begin
         exp_frames++;
         e.cyc   = t0 + RSP_OFS - 1;
         e.falls = exp_frames;
      end
      exp_q.push_back(e);
      @(negedge clk);
      if (!hold) bus.req_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check(name, 64'(exp_q.size()), 64'h0);
   endtask

   // Monitor: cs_n edge bookkeeping and response comparison against the scoreboard.
   initial begin
      logic prev_cs;
      exp_t e;
      prev_cs   = 1'b1;
      cs_falls  = 0;
      last_rise = 0;
      last_gap  = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_cs = 1'b1;
         end else begin
            if (prev_cs && !cs_n) begin
               cs_falls++;
               last_gap = cyc - last_rise;
            end
            if (!prev_cs && cs_n) last_rise = cyc;
            prev_cs = cs_n;
            if (bus.rsp_valid) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_rsp", 64'h1, 64'h0);
               end else begin
                  e = exp_q.pop_front();
                  check("rsp_rdata", {48'h0, bus.rsp_rdata}, {48'h0, e.rdata});
                  check("rsp_err", {63'h0, bus.rsp_err}, {63'h0, e.err});
                  check("rsp_time", 64'(cyc), 64'(e.cyc));
                  check("cs_frames", 64'(cs_falls), 64'(e.falls));
                  if (e.has_frame) begin
                     check("frame_bits", 64'(ncap), 64'(FRAME));
                     check("frame_data", {24'h0, cap}, {24'h0, e.frame});
                  end
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1);
   end

   initial begin
      int t0a;
      int t0b;
      int n;
      rst           = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_rd    = 1'b0;
      bus.req_addr  = 16'h0;
      bus.req_wdata = 16'h0;
      sl_word       = {24'h0, 16'hBEEF};
      ncomp         = 0;
      nfail         = 0;
      exp_frames    = 0;
      repeat (3) @(negedge clk);
      check("rst_cs_n", {63'h0, cs_n}, 64'h1);
      check("rst_sclk", {63'h0, sclk}, 64'h0);
      check("rst_mosi", {63'h0, mosi}, 64'h0);
      check("rst_ready", {63'h0, bus.req_ready}, 64'h1);
      check("rst_rsp_valid", {63'h0, bus.rsp_valid}, 64'h0);
      check("rst_rsp_err", {63'h0, bus.rsp_err}, 64'h0);
      check("rst_rsp_rdata", {48'h0, bus.rsp_rdata}, 64'h0);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check("idle_cs_n", {63'h0, cs_n}, 64'h1);
      check("idle_sclk", {63'h0, sclk}, 64'h0);
      check("idle_mosi", {63'h0, mosi}, 64'h0);
      check("idle_ready", {63'h0, bus.req_ready}, 64'h1);

      // Single write.
      send(1'b0, 16'h0001, 16'h0100, 1'b0, 16'h0000, 1'b0, 40'h01_0001_0100, t0a);
      drain("write1_drain");

`ifdef SPI_CFG_MASTER_READ_EN
      // Read: write data is ignored, slave returns 0xBEEF in the data field.
      send(1'b1, 16'h0010, 16'hFFFF, 1'b0, 16'hBEEF, 1'b0, 40'h02_0010_0000, t0a);
      drain("read_drain");
`endif

      // Back-to-back writes; second request's fields change while the first is busy.
      send(1'b0, 16'h00A5, 16'h5A3C, 1'b1, 16'h0000, 1'b0, 40'h01_00A5_5A3C, t0a);
      send(1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 40'h01_FFFF_FFFF, t0b);
      @(negedge clk);
      check("b2b_cs_gap", 64'(last_gap), 64'(CLK_DIV + 1));
      check("b2b_accept", 64'(t0b - t0a), 64'((2 * FRAME + 2) * CLK_DIV + 1));
      drain("b2b_drain");

      // Reset in the middle of a write frame.
      send(1'b0, 16'h1357, 16'h2468, 1'b0, 16'h0000, 1'b0, 40'h01_1357_2468, t0a);
      n = 0;
      while (ncap < 20 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("abort_reached_bit20", 64'(ncap), 64'd20);
      #3;
      rst = 1'b1;
      void'(exp_q.pop_back());
      #1;
      check("abort_cs_n", {63'h0, cs_n}, 64'h1);
      check("abort_sclk", {63'h0, sclk}, 64'h0);
      check("abort_ready", {63'h0, bus.req_ready}, 64'h1);
      check("abort_rsp_valid", {63'h0, bus.rsp_valid}, 64'h0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      send(1'b0, 16'h0002, 16'h1234, 1'b0, 16'h0000, 1'b0, 40'h01_0002_1234, t0a);
      drain("post_reset_drain");

`ifndef SPI_CFG_MASTER_READ_EN
      // Read without read support: immediate error response, no SPI frame.
      send(1'b1, 16'h0010, 16'h0000, 1'b0, 16'h0000, 1'b1, 40'h0, t0a);
      send(1'b0, 16'h00C3, 16'h8001, 1'b0, 16'h0000, 1'b0, 40'h01_00C3_8001, t0b);
      check("reject_ready_return", 64'(t0b - t0a), 64'd2);
      drain("reject_drain");
`endif

      repeat (5) @(negedge clk);
      check("pending", 64'(exp_q.size()), 64'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
      $finish;
   end
endmodule
